fir_mac_sched: RTL

- Time-shared FIR engine: one 16x16 signed multiplier and one accumulator, sequenced across N_TAPS taps per input sample.
- Coefficients are held in a runtime-writable register file.
- Sits between a valid/ready sample source and a downstream stage that expects a one-cycle o_valid strobe.
- Replaces the fully parallel 4-multiplier FIR where area matters more than throughput.

---
 rtl/fir_mac_sched_if.sv | 40 ++++
 rtl/fir_mac_sched.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fir_mac_sched_if.sv
// Sample, coefficient and result signals for fir_mac_sched.
// With FIR_MAC_SAT_FLAG_EN defined, the bundle also carries o_sat / i_sat_clr.
interface fir_mac_sched_if #(
  parameter int NB_INPUT  = 16,
  parameter int NB_COEF   = 16,
  parameter int NB_OUTPUT = 18,
  parameter int N_TAPS    = 4
);
  localparam int AW = $clog2(N_TAPS);

  logic signed [NB_INPUT-1:0]  i_data;
  logic                        i_valid;
  logic                        o_ready;
  logic                        i_coef_we;
  logic [AW-1:0]               i_coef_addr;
  logic signed [NB_COEF-1:0]   i_coef_data;
  logic                        o_coef_err;
  logic signed [NB_OUTPUT-1:0] o_data;
  logic                        o_valid;
`ifdef FIR_MAC_SAT_FLAG_EN
  logic                        o_sat;
  logic                        i_sat_clr;
`endif

  modport master (
    output i_data, i_valid, i_coef_we, i_coef_addr, i_coef_data,
    input  o_ready, o_coef_err, o_data, o_valid
`ifdef FIR_MAC_SAT_FLAG_EN
    , output i_sat_clr, input o_sat
`endif
  );

  modport slave (
    input  i_data, i_valid, i_coef_we, i_coef_addr, i_coef_data,
    output o_ready, o_coef_err, o_data, o_valid
`ifdef FIR_MAC_SAT_FLAG_EN
    , input i_sat_clr, output o_sat
`endif
  );
endinterface

// File: rtl/fir_mac_sched.sv
// Time-shared FIR: one multiplier + accumulator stepped over N_TAPS taps per sample.
// Optional sticky saturation flag with FIR_MAC_SAT_FLAG_EN.
//   state  | meaning
//   IDLE   | ready for a sample; coefficient writes accepted
//   MAC    | one tap per cycle, k = 0..N_TAPS-1
//   OUT    | register the sum and strobe o_valid
module fir_mac_sched #(
  parameter int NB_INPUT  = 16,
  parameter int NB_COEF   = 16,
  parameter int NB_OUTPUT = 18,
  parameter int N_TAPS    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  fir_mac_sched_if.slave bus
);
  localparam int AW = $clog2(N_TAPS);
  localparam int NP = NB_INPUT + NB_COEF;
  localparam int FB = NB_COEF - 1;
  localparam int SW = NP + 1 - FB;
  localparam logic signed [NP:0]   HALF  = (NP+1)'(2 ** (FB - 1));
  localparam logic signed [SW-1:0] T_MAX = SW'((2 ** (NB_INPUT - 1)) - 1);
  localparam logic signed [SW-1:0] T_MIN = ~T_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t state_q, state_d;
  logic signed [NB_INPUT-1:0]  x_q    [N_TAPS];
  logic signed [NB_COEF-1:0]   coef_q [N_TAPS];
  logic [AW-1:0]               tap_q;
  logic signed [NB_OUTPUT-1:0] acc_q;
  logic signed [NB_OUTPUT-1:0] data_q;
  logic                        valid_q;
  logic                        err_q;

  logic accept, mac_en, out_en, last_tap, addr_ok, coef_wr, coef_drop;
  logic signed [NP-1:0]       prod;
  logic signed [NP:0]         rnd;
  logic signed [SW-1:0]       rsh;
  logic signed [NB_INPUT-1:0] t;
  logic                       sat_hi, sat_lo;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.i_valid) state_d = S_MAC;
      S_MAC:   if (last_tap)    state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready = 1'b0;
    accept      = 1'b0;
    mac_en      = 1'b0;
    out_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.o_ready = 1'b1;
        accept      = bus.i_valid;
      end
      S_MAC:   mac_en = 1'b1;
      S_OUT:   out_en = 1'b1;
      default: ;
    endcase
  end

  assign last_tap = (tap_q == AW'(N_TAPS - 1));

  // Address range can only be exceeded when N_TAPS is not a power of two.
  if ((1 << AW) == N_TAPS) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_chk
    assign addr_ok = (int'(bus.i_coef_addr) < N_TAPS);
  end

  assign coef_wr   = bus.i_coef_we && (state_q == S_IDLE) && addr_ok;
  assign coef_drop = bus.i_coef_we && !coef_wr;

  // Round half up at the Q15 point, then clamp back to the sample range.
  assign prod = x_q[tap_q] * coef_q[tap_q];
  assign rnd  = {prod[NP-1], prod} + HALF;
  assign rsh  = SW'(rnd >>> FB);

  always_comb begin
    sat_hi = (rsh > T_MAX);
    sat_lo = (rsh < T_MIN);
    if (sat_hi)      t = T_MAX[NB_INPUT-1:0];
    else if (sat_lo) t = T_MIN[NB_INPUT-1:0];
    else             t = rsh[NB_INPUT-1:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < N_TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
      tap_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= out_en;
      err_q   <= coef_drop;
      if (coef_wr) coef_q[bus.i_coef_addr] <= bus.i_coef_data;
      if (accept) begin
        x_q[0] <= bus.i_data;
        for (int k = 1; k < N_TAPS; k++) x_q[k] <= x_q[k-1];
        tap_q <= '0;
        acc_q <= '0;
      end else if (mac_en) begin
        acc_q <= acc_q + NB_OUTPUT'(t);
        tap_q <= last_tap ? '0 : tap_q + 1'b1;
      end
      if (out_en) data_q <= acc_q;
    end
  end

  assign bus.o_data     = data_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_coef_err = err_q;

`ifdef FIR_MAC_SAT_FLAG_EN
  logic sat_q;

  // A clamp in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                          sat_q <= 1'b0;
    else if (mac_en && (sat_hi || sat_lo)) sat_q <= 1'b1;
    else if (bus.i_sat_clr)             sat_q <= 1'b0;
  end

  assign bus.o_sat = sat_q;
`endif
endmodule
